pwm_bank: RTL and testbench
===========================

# pwm_bank

Parametrised multi-channel PWM generator, the next generation of the servo PWM block behind the I2C register bridge. Produces NUM_CH edge-aligned PWM outputs from one shared period counter advanced by a clock-enable prescaler (no derived clocks). Duty and period registers are double-buffered and transfer to the active set only at period boundaries, so outputs never glitch. Per-channel enable and polarity masks are included. Register port attaches directly to the i2cSlave Addr/Out/In/WEn signals.

## Interface
- NUM_CH, 8, number of channels, 1..32
- CNT_W, 16, width of period counter, duty and period registers, 9..16
- PRESCALE, 50, Clk cycles per counter tick (50 MHz → 1 µs), ≥2
- PERIOD_RST, 20000, reset period in ticks
- Clk  in  1  sole clock, rising edge
- Rst_n  in  1  asynchronous active-low reset
- Addr  in  8  register byte address
- WrData  in  8  write data
- WEn  in  1  write strobe, one Clk per byte
- RdData  out  8  read data, combinational from Addr
- PwmOut  out  NUM_CH  PWM outputs, registered
- PeriodStart  out  1  one-Clk pulse when counter wraps to 0

## Operation
- Map: 0x00+2n / 0x01+2n = duty[n] low/high byte (n<NUM_CH). 0x40/0x41 = period low/high. 0x42 = CTRL, bit0 GEN (global enable). 0x44–0x47 = channel enable mask bytes. 0x48–0x4B = polarity mask bytes. Bits beyond CNT_W or NUM_CH read 0, ignore writes. Unmapped addresses read 0x00, ignore writes.
- Reads return shadow values.
- Writing a low byte sets that register's pending flag. Writing the high byte clears it. Shadow→active transfer of a register is skipped while it is pending.
- Period shadow value 0 is stored as 1.
- Prescaler: counts 0..PRESCALE-1. tick = 1 on the cycle it equals PRESCALE-1.
- Counter: on tick, if cnt == period_act-1 then cnt←0, transfer all non-pending shadows to active, and assert PeriodStart for that Clk. Otherwise cnt←cnt+1.
- raw[n] = GEN & en[n] & (cnt < duty_act[n]). PwmOut[n] ← raw[n] ^ pol[n]. Enable and polarity masks take effect immediately, not double-buffered.
- Duty 0 → always inactive. Duty ≥ period_act → always active.
- GEN=0: prescaler and cnt held at 0. Every non-pending shadow is copied to active each Clk. No PeriodStart. When GEN goes 1, counting starts from cnt=0, and the first PeriodStart occurs at the first wrap.

## Timing
- Reset values: all duty shadow/active 0, period PERIOD_RST, masks 0, GEN 0, pending 0, cnt 0, prescaler 0, PwmOut 0, PeriodStart 0.
- Register write takes effect on the Clk edge where WEn=1. RdData reflects it in the next cycle.
- PwmOut lags cnt by one Clk. Rising edges of non-inverted channels occur one Clk after PeriodStart.
- Period length = period_act × PRESCALE Clk.
- A write on the same edge as a transfer: transfer uses the pre-write shadow, and pending logic uses the pre-write flag.
- Rst_n asserted mid-period: all state clears asynchronously, and PwmOut goes 0 immediately, regardless of polarity.

## Structure
- pwm_pkg: address constants (DUTY_BASE, PERIOD_LO/HI, CTRL, EN_BASE, POL_BASE), CTRL_GEN bit index, MAX_CH=32.
- One sub-module, pwm_channel: holds duty shadow/active, the pending flag, the comparator and the output flop. It is instantiated NUM_CH times. The top level holds the prescaler, counter, period registers and address decode.

## Test plan
Bench uses PRESCALE=2, NUM_CH=4.
- Reset: PwmOut=0, RdData@0x40/0x41 = 0x20/0x4E (20000).
- Basic duty: period=10, duty0=3, en=0x1, GEN=1 → PwmOut[0] high 6 Clk, low 14 Clk. PeriodStart every 20 Clk.
- Mid-period change: write duty0=7 mid-period → current period keeps 3. The next period after PeriodStart is high for 14 Clk.
- Pending flag: write duty1 low byte only, let a wrap pass, then write the high byte → active is unchanged until the next wrap after the high write.
- Polarity and edges: pol=0x4, en=0x4, duty2=0 → PwmOut[2] constantly 1. duty2=12 with period 10 → constantly 0.
- Mid-stream reset: pulse Rst_n low mid-high phase → PwmOut=0 asynchronously, and all registers read their reset values.

Source files
------------

// File: rtl/pwm_pkg.sv
// ---------------------------------------------------------------------------
// pwm_pkg
// Shared constants for the PWM bank: register byte addresses of the
// I2C-facing map, the global-enable bit position in CTRL and the largest
// supported channel count.
// ---------------------------------------------------------------------------
package pwm_pkg;

   localparam int MAX_CH = 32;

   // duty[n] low byte lives at DUTY_BASE + 2n, high byte at DUTY_BASE + 2n + 1
   localparam logic [7:0] DUTY_BASE = 8'h00;
   localparam logic [7:0] PERIOD_LO = 8'h40;
   localparam logic [7:0] PERIOD_HI = 8'h41;
   localparam logic [7:0] CTRL      = 8'h42;
   // four mask bytes each, channel 8k+j is bit j of byte BASE + k
   localparam logic [7:0] EN_BASE   = 8'h44;
   localparam logic [7:0] POL_BASE  = 8'h48;

   localparam int CTRL_GEN = 0;

endpackage

// File: rtl/pwm_channel.sv
// ---------------------------------------------------------------------------
// pwm_channel
// One PWM channel: double-buffered duty register (shadow written over the
// register port, active used by the comparator), the pending flag that
// blocks a half-written duty from being transferred, and the output flop.
//
// Ports
//   Clk, Rst_n    clock, asynchronous active-low reset
//   WrData        register write byte
//   wr_lo, wr_hi  write strobes for the duty low / high byte
//   xfer          shadow-to-active transfer request (period wrap or GEN=0)
//   gen           global enable
//   en, pol       this channel's enable and polarity mask bits
//   cnt           shared period counter
//   duty_shadow   shadow duty value, for register read-back
//   pwm           registered PWM output
// ---------------------------------------------------------------------------
module pwm_channel #(
   parameter int CNT_W = 16
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic [7:0]       WrData,
   input  logic             wr_lo,
   input  logic             wr_hi,
   input  logic             xfer,
   input  logic             gen,
   input  logic             en,
   input  logic             pol,
   input  logic [CNT_W-1:0] cnt,
   output logic [CNT_W-1:0] duty_shadow,
   output logic             pwm
);

   logic [CNT_W-1:0] duty_act;
   logic             pending;

   // The transfer samples the shadow and pending flag as they were before
   // this edge, so a write landing on a wrap edge only affects later
   // periods. A low-byte write arms pending; the high-byte write releases it.
   // The output flop compares against the active duty, giving one Clk of
   // lag behind the counter, and reset forces it low whatever the polarity.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         duty_shadow <= '0;
         duty_act    <= '0;
         pending     <= 1'b0;
         pwm         <= 1'b0;
      end else begin
         if (xfer && !pending)
            duty_act <= duty_shadow;
         if (wr_lo) begin
            duty_shadow <= {duty_shadow[CNT_W-1:8], WrData};
            pending     <= 1'b1;
         end else if (wr_hi) begin
            duty_shadow <= CNT_W'({WrData, duty_shadow[7:0]});
            pending     <= 1'b0;
         end
         pwm <= (gen & en & (cnt < duty_act)) ^ pol;
      end
   end

endmodule

// File: rtl/pwm_bank.sv
// ---------------------------------------------------------------------------
// pwm_bank
// NUM_CH edge-aligned PWM outputs sharing one period counter that advances
// on a prescaler clock-enable. Duty and period are double-buffered and only
// move to the active set at period boundaries (or continuously while GEN=0).
//
// Ports
//   Clk          sole clock, rising edge
//   Rst_n        asynchronous active-low reset
//   Addr         register byte address (i2cSlave Addr)
//   WrData       write byte (i2cSlave Out)
//   WEn          write strobe, one Clk per byte
//   RdData       combinational read-back of the addressed shadow byte
//   PwmOut       registered PWM outputs
//   PeriodStart  one-Clk pulse while the counter sits at 0 after a wrap
// ---------------------------------------------------------------------------
module pwm_bank
   import pwm_pkg::*;
#(
   parameter int NUM_CH     = 8,
   parameter int CNT_W      = 16,
   parameter int PRESCALE   = 50,
   parameter int PERIOD_RST = 20000
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic [7:0]        Addr,
   input  logic [7:0]        WrData,
   input  logic              WEn,
   output logic [7:0]        RdData,
   output logic [NUM_CH-1:0] PwmOut,
   output logic              PeriodStart
);

   localparam int PRESC_W = $clog2(PRESCALE);

   logic [PRESC_W-1:0] presc;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   period_sh;
   logic [CNT_W-1:0]   period_act;
   logic               period_pend;
   logic               gen;
   logic               tick;
   logic               wrap;
   logic               xfer;
   logic [NUM_CH-1:0]  en;
   logic [NUM_CH-1:0]  pol;
   logic [MAX_CH-1:0]  en_wide;
   logic [MAX_CH-1:0]  pol_wide;
   logic [CNT_W-1:0]   duty_sh [NUM_CH];
   logic [NUM_CH:0][7:0] duty_rd;

   // A zero period would never wrap, so it is stored as one tick.
   function automatic logic [CNT_W-1:0] no_zero(input logic [CNT_W-1:0] v);
      return (v == '0) ? CNT_W'(1) : v;
   endfunction

   assign tick = gen && (presc == PRESC_W'(PRESCALE - 1));
   assign wrap = tick && (cnt == period_act - 1'b1);
   assign xfer = !gen || wrap;

   // Prescaler and period counter. With GEN low both are parked at zero, so
   // enabling starts a full first period and PeriodStart stays quiet until
   // the first real wrap.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         presc       <= '0;
         cnt         <= '0;
         PeriodStart <= 1'b0;
      end else if (!gen) begin
         presc       <= '0;
         cnt         <= '0;
         PeriodStart <= 1'b0;
      end else begin
         PeriodStart <= wrap;
         presc       <= tick ? '0 : presc + 1'b1;
         if (tick)
            cnt <= wrap ? '0 : cnt + 1'b1;
      end
   end

   // Period shadow/active pair with the same pending handshake as the duty
   // registers, plus the global enable bit.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         period_sh   <= CNT_W'(PERIOD_RST);
         period_act  <= CNT_W'(PERIOD_RST);
         period_pend <= 1'b0;
         gen         <= 1'b0;
      end else begin
         if (xfer && !period_pend)
            period_act <= period_sh;
         if (WEn && Addr == PERIOD_LO) begin
            period_sh   <= no_zero({period_sh[CNT_W-1:8], WrData});
            period_pend <= 1'b1;
         end else if (WEn && Addr == PERIOD_HI) begin
            period_sh   <= no_zero(CNT_W'({WrData, period_sh[7:0]}));
            period_pend <= 1'b0;
         end
         if (WEn && Addr == CTRL)
            gen <= WrData[CTRL_GEN];
      end
   end

   // Per-channel address decode, mask bits and channel instance. Each
   // channel also drives its slice of the duty read-back OR chain.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      localparam logic [7:0] LO_ADDR  = DUTY_BASE + 8'(2 * i);
      localparam logic [7:0] HI_ADDR  = DUTY_BASE + 8'(2 * i + 1);
      localparam logic [7:0] EN_ADDR  = EN_BASE + 8'(i / 8);
      localparam logic [7:0] POL_ADDR = POL_BASE + 8'(i / 8);

      // Masks act immediately; they are not double-buffered.
      always_ff @(posedge Clk or negedge Rst_n) begin
         if (!Rst_n) begin
            en[i]  <= 1'b0;
            pol[i] <= 1'b0;
         end else begin
            if (WEn && Addr == EN_ADDR)
               en[i] <= WrData[i % 8];
            if (WEn && Addr == POL_ADDR)
               pol[i] <= WrData[i % 8];
         end
      end

      pwm_channel #(.CNT_W(CNT_W)) u_ch (
         .Clk         (Clk),
         .Rst_n       (Rst_n),
         .WrData      (WrData),
         .wr_lo       (WEn && Addr == LO_ADDR),
         .wr_hi       (WEn && Addr == HI_ADDR),
         .xfer        (xfer),
         .gen         (gen),
         .en          (en[i]),
         .pol         (pol[i]),
         .cnt         (cnt),
         .duty_shadow (duty_sh[i]),
         .pwm         (PwmOut[i])
      );

      assign duty_rd[i+1] = duty_rd[i] |
                            ((Addr == LO_ADDR) ? duty_sh[i][7:0]      :
                             (Addr == HI_ADDR) ? 8'(duty_sh[i] >> 8)  : 8'h00);
   end

   assign duty_rd[0] = 8'h00;
   assign en_wide    = MAX_CH'(en);
   assign pol_wide   = MAX_CH'(pol);

   // Read-back of shadow values. Mask bytes are zero-extended to 32 bits so
   // channels that do not exist read as 0; any unmapped address reads 0.
   always_comb begin
      RdData = 8'h00;
      if (Addr == PERIOD_LO)
         RdData = period_sh[7:0];
      else if (Addr == PERIOD_HI)
         RdData = 8'(period_sh >> 8);
      else if (Addr == CTRL)
         RdData[CTRL_GEN] = gen;
      else if (Addr[7:2] == EN_BASE[7:2])
         RdData = en_wide[{Addr[1:0], 3'b000} +: 8];
      else if (Addr[7:2] == POL_BASE[7:2])
         RdData = pol_wide[{Addr[1:0], 3'b000} +: 8];
      else
         RdData = duty_rd[NUM_CH];
   end

endmodule

// File: tb/tb_pwm_bank.sv
// ---------------------------------------------------------------------------
// tb_pwm_bank
// Directed bench for pwm_bank (NUM_CH=4, PRESCALE=2). A behavioural model
// tracks elapsed Clk cycles within the period and the register map, and a
// negedge process compares PwmOut/PeriodStart with it every cycle. Directed
// sections add hand-computed counts of high cycles per period.
// ---------------------------------------------------------------------------
module tb_pwm_bank;

   localparam int NCH = 4;
   localparam int PSC = 2;

   logic           Clk;
   logic           Rst_n;
   logic [7:0]     Addr;
   logic [7:0]     WrData;
   logic           WEn;
   logic [7:0]     RdData;
   logic [NCH-1:0] PwmOut;
   logic           PeriodStart;

   int checks   = 0;
   int failures = 0;

   pwm_bank #(
      .NUM_CH     (NCH),
      .CNT_W      (16),
      .PRESCALE   (PSC),
      .PERIOD_RST (20000)
   ) dut (
      .Clk         (Clk),
      .Rst_n       (Rst_n),
      .Addr        (Addr),
      .WrData      (WrData),
      .WEn         (WEn),
      .RdData      (RdData),
      .PwmOut      (PwmOut),
      .PeriodStart (PeriodStart)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Behavioural model state: elapsed Clk cycles inside the period rather
   // than a prescaler/counter pair.
   int unsigned m_duty_sh  [NCH];
   int unsigned m_duty_act [NCH];
   bit          m_dpend    [NCH];
   int unsigned m_per_sh;
   int unsigned m_per_act;
   bit          m_ppend;
   bit [NCH-1:0] m_en;
   bit [NCH-1:0] m_pol;
   bit          m_gen;
   int unsigned m_t;
   bit [NCH-1:0] exp_pwm;
   bit          exp_ps;
   bit          m_xfer;
   int unsigned m_tick;

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model update, evaluated with the inputs that the DUT sees on this edge.
   always @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         for (int c = 0; c < NCH; c++) begin
            m_duty_sh[c] = 0; m_duty_act[c] = 0; m_dpend[c] = 0;
         end
         m_per_sh = 20000; m_per_act = 20000; m_ppend = 0;
         m_en = '0; m_pol = '0; m_gen = 0; m_t = 0;
         exp_pwm = '0; exp_ps = 0;
      end else begin
         m_tick = m_t / PSC;
         for (int c = 0; c < NCH; c++)
            exp_pwm[c] = (m_gen && m_en[c] && (m_tick < m_duty_act[c])) ^ m_pol[c];
         m_xfer = 0;
         exp_ps = 0;
         if (!m_gen) begin
            m_t = 0;
            m_xfer = 1;
         end else begin
            m_t++;
            if (m_t == m_per_act * PSC) begin
               m_t = 0; m_xfer = 1; exp_ps = 1;
            end
         end
         if (m_xfer) begin
            for (int c = 0; c < NCH; c++)
               if (!m_dpend[c]) m_duty_act[c] = m_duty_sh[c];
            if (!m_ppend) m_per_act = m_per_sh;
         end
         if (WEn) begin
            if (Addr < 8'(2 * NCH)) begin
               if (Addr[0] == 1'b0) begin
                  m_duty_sh[Addr >> 1] = (m_duty_sh[Addr >> 1] & 32'hFF00) | WrData;
                  m_dpend[Addr >> 1] = 1;
               end else begin
                  m_duty_sh[Addr >> 1] = (m_duty_sh[Addr >> 1] & 32'h00FF) | (32'(WrData) << 8);
                  m_dpend[Addr >> 1] = 0;
               end
            end else if (Addr == 8'h40) begin
               m_per_sh = (m_per_sh & 32'hFF00) | WrData;
               if (m_per_sh == 0) m_per_sh = 1;
               m_ppend = 1;
            end else if (Addr == 8'h41) begin
               m_per_sh = (m_per_sh & 32'h00FF) | (32'(WrData) << 8);
               if (m_per_sh == 0) m_per_sh = 1;
               m_ppend = 0;
            end else if (Addr == 8'h42) begin
               m_gen = WrData[0];
            end else if (Addr == 8'h44) begin
               m_en = WrData[NCH-1:0];
            end else if (Addr == 8'h48) begin
               m_pol = WrData[NCH-1:0];
            end
         end
      end
   end

   // Every-cycle comparison against the model while out of reset.
   always @(negedge Clk) begin
      if (Rst_n === 1'b1) begin
         checkOutput("pwm_model", 32'(PwmOut), 32'(exp_pwm));
         checkOutput("ps_model", 32'(PeriodStart), 32'(exp_ps));
      end
   end

   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] d);
      @(negedge Clk);
      Addr = a; WrData = d; WEn = 1'b1;
      @(negedge Clk);
      WEn = 1'b0;
   endtask

   task automatic readReg(input string name, input logic [7:0] a, input logic [7:0] exp);
      Addr = a;
      #1;
      checkOutput(name, 32'(RdData), 32'(exp));
   endtask

   task automatic waitPS();
      bit found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge Clk);
         if (PeriodStart) found = 1;
      end
      if (!found) checkOutput("ps_timeout", 32'd0, 32'd1);
   endtask

   task automatic countHigh(input int ch, input int n, output int high, output int psIdx);
      high = 0; psIdx = -1;
      for (int i = 1; i <= n; i++) begin
         @(negedge Clk);
         if (PwmOut[ch]) high++;
         if (PeriodStart) psIdx = i;
      end
   endtask

   int hi;
   int psi;

   initial begin
      Rst_n = 1'b0; WEn = 1'b0; Addr = 8'h00; WrData = 8'h00;
      #23;
      // Reset state
      checkOutput("reset_pwm", 32'(PwmOut), 32'h0);
      readReg("reset_per_lo", 8'h40, 8'h20);
      readReg("reset_per_hi", 8'h41, 8'h4E);
      @(negedge Clk); #2 Rst_n = 1'b1;

      // Basic duty: period 10 ticks, duty0 = 3
      applyStimulus(8'h40, 8'd10);
      applyStimulus(8'h41, 8'd0);
      applyStimulus(8'h00, 8'd3);
      applyStimulus(8'h01, 8'd0);
      readReg("duty0_rd", 8'h00, 8'h03);
      readReg("per_rd", 8'h40, 8'h0A);
      applyStimulus(8'h44, 8'h01);
      applyStimulus(8'h42, 8'h01);
      readReg("ctrl_rd", 8'h42, 8'h01);
      waitPS();
      countHigh(0, 20, hi, psi);
      checkOutput("basic_high", 32'(hi), 32'd6);
      checkOutput("basic_ps_interval", 32'(psi), 32'd20);

      // Mid-period duty change: current period keeps duty 3
      hi = 0; psi = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge Clk);
         if (PwmOut[0]) hi++;
         if (PeriodStart) psi = i;
         if (i == 8)  begin Addr = 8'h00; WrData = 8'd7; WEn = 1'b1; end
         if (i == 9)  begin Addr = 8'h01; WrData = 8'd0; end
         if (i == 10) WEn = 1'b0;
      end
      checkOutput("mid_keep_high", 32'(hi), 32'd6);
      checkOutput("mid_ps_interval", 32'(psi), 32'd20);
      countHigh(0, 20, hi, psi);
      checkOutput("mid_new_high", 32'(hi), 32'd14);

      // Pending flag on duty1
      applyStimulus(8'h44, 8'h03);
      applyStimulus(8'h02, 8'd5);
      waitPS();
      countHigh(1, 20, hi, psi);
      checkOutput("pend_lo_only", 32'(hi), 32'd0);
      applyStimulus(8'h03, 8'd0);
      countHigh(1, 18, hi, psi);
      checkOutput("pend_after_hi", 32'(hi), 32'd0);
      countHigh(1, 20, hi, psi);
      checkOutput("pend_next_wrap", 32'(hi), 32'd10);

      // Polarity: inverted channel 2
      applyStimulus(8'h48, 8'h04);
      applyStimulus(8'h44, 8'h04);
      countHigh(2, 20, hi, psi);
      checkOutput("pol_duty0", 32'(hi), 32'd20);
      applyStimulus(8'h04, 8'd12);
      applyStimulus(8'h05, 8'd0);
      waitPS();
      countHigh(2, 20, hi, psi);
      checkOutput("pol_duty_over", 32'(hi), 32'd0);

      // Mid-stream reset during the high phase
      applyStimulus(8'h04, 8'd0);
      applyStimulus(8'h05, 8'd0);
      applyStimulus(8'h44, 8'h05);
      waitPS();
      @(negedge Clk);
      @(negedge Clk);
      checkOutput("pre_reset_pwm", 32'(PwmOut), 32'h5);
      #2 Rst_n = 1'b0;
      #1 checkOutput("async_reset_pwm", 32'(PwmOut), 32'h0);
      checkOutput("async_reset_ps", 32'(PeriodStart), 32'h0);
      readReg("rst_per_lo", 8'h40, 8'h20);
      readReg("rst_per_hi", 8'h41, 8'h4E);
      readReg("rst_duty0", 8'h00, 8'h00);
      readReg("rst_ctrl", 8'h42, 8'h00);
      readReg("rst_en", 8'h44, 8'h00);
      readReg("rst_pol", 8'h48, 8'h00);
      @(negedge Clk); #2 Rst_n = 1'b1;

      // Register-map boundaries
      applyStimulus(8'h40, 8'h00);
      readReg("per_lo0", 8'h40, 8'h00);
      applyStimulus(8'h41, 8'h00);
      readReg("per_zero_lo", 8'h40, 8'h01);
      readReg("per_zero_hi", 8'h41, 8'h00);
      applyStimulus(8'h08, 8'h55);
      readReg("no_ch4", 8'h08, 8'h00);
      readReg("unmapped", 8'h50, 8'h00);
      applyStimulus(8'h00, 8'hAB);
      applyStimulus(8'h01, 8'hCD);
      readReg("duty0_lo", 8'h00, 8'hAB);
      readReg("duty0_hi", 8'h01, 8'hCD);
      applyStimulus(8'h44, 8'hFF);
      applyStimulus(8'h45, 8'hFF);
      readReg("en_mask", 8'h44, 8'h0F);
      readReg("en_byte1", 8'h45, 8'h00);
      applyStimulus(8'h42, 8'hFE);
      readReg("ctrl_bit0", 8'h42, 8'h00);
      repeat (4) @(negedge Clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
